// File: rtl/energy_tracker.sv
// energy_tracker: collects a configured number of signed energy samples,
// tracking the minimum (value and earliest index), the number of samples at or
// below a signed threshold, and a sticky "threshold hit" flag. Results are held
// in registers and offered through a valid/ready handshake.
module energy_tracker #(
    parameter int ENERGY_W = 32,
    parameter int CNT_W    = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                clear_i,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [CNT_W-1:0]    cfg_num_samples_i,
    input  logic [ENERGY_W-1:0] cfg_threshold_i,
    input  logic                energy_valid_i,
    output logic                energy_ready_o,
    input  logic [ENERGY_W-1:0] energy_i,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ENERGY_W-1:0] min_energy_o,
    output logic [CNT_W-1:0]    min_index_o,
    output logic [CNT_W-1:0]    hit_cnt_o,
    output logic                thr_hit_o,
    output logic                busy_o
);

    // Most positive signed value: the "nothing seen yet" minimum.
    localparam logic signed [ENERGY_W-1:0] E_MAX = {1'b0, {(ENERGY_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [CNT_W-1:0]           num_samples_reg, num_samples_next;
    logic signed [ENERGY_W-1:0] threshold_reg, threshold_next;
    logic signed [ENERGY_W-1:0] min_energy_reg, min_energy_next;
    logic [CNT_W-1:0]           min_index_reg, min_index_next;
    logic [CNT_W-1:0]           hit_cnt_reg, hit_cnt_next;
    logic                       thr_hit_reg, thr_hit_next;
    logic [CNT_W-1:0]           sample_cnt_reg, sample_cnt_next;

    logic                       cfg_fire;
    logic                       energy_fire;
    logic                       result_fire;
    logic                       last_sample;
    logic [CNT_W-1:0]           cnt_inc;
    logic signed [ENERGY_W-1:0] energy_s;

    assign energy_s = $signed(energy_i);
    assign cnt_inc  = sample_cnt_reg + CNT_ONE;

    // Handshake outputs, fire strobes and next-state selection; clear wins over everything.
    always_comb begin
        cfg_ready_o    = 1'b0;
        energy_ready_o = 1'b0;
        result_valid_o = 1'b0;
        busy_o         = 1'b0;
        state_next     = state_reg;

        case (state_reg)
            S_IDLE: begin
                cfg_ready_o = en_i;
            end
            S_RUN: begin
                energy_ready_o = en_i;
                busy_o         = 1'b1;
            end
            S_REPORT: begin
                result_valid_o = en_i;
                busy_o         = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase

        cfg_fire    = cfg_valid_i && cfg_ready_o;
        energy_fire = energy_valid_i && energy_ready_o;
        result_fire = result_valid_o && result_ready_i;
        // Accept that brings the count up to the configured total ends the run.
        last_sample = (cnt_inc == num_samples_reg);

        case (state_reg)
            S_IDLE: begin
                if (cfg_fire) begin
                    state_next = (cfg_num_samples_i == '0) ? S_REPORT : S_RUN;
                end
            end
            S_RUN: begin
                if (energy_fire && last_sample) begin
                    state_next = S_REPORT;
                end
            end
            S_REPORT: begin
                if (result_fire) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                // Unreachable encodings fall back to a clean idle.
                state_next = S_IDLE;
            end
        endcase

        if (clear_i) begin
            state_next = S_IDLE;
        end
    end

    // Statistics update: clear restores reset values, config starts a new run,
    // each energy accept folds one sample into the running stats.
    always_comb begin
        num_samples_next = num_samples_reg;
        threshold_next   = threshold_reg;
        min_energy_next  = min_energy_reg;
        min_index_next   = min_index_reg;
        hit_cnt_next     = hit_cnt_reg;
        thr_hit_next     = thr_hit_reg;
        sample_cnt_next  = sample_cnt_reg;

        if (clear_i) begin
            num_samples_next = '0;
            threshold_next   = '0;
            min_energy_next  = E_MAX;
            min_index_next   = '0;
            hit_cnt_next     = '0;
            thr_hit_next     = 1'b0;
            sample_cnt_next  = '0;
        end else if (cfg_fire) begin
            num_samples_next = cfg_num_samples_i;
            threshold_next   = $signed(cfg_threshold_i);
            min_energy_next  = E_MAX;
            min_index_next   = '0;
            hit_cnt_next     = '0;
            thr_hit_next     = 1'b0;
            sample_cnt_next  = '0;
        end else if (energy_fire) begin
            // Strict less-than keeps the earliest index on ties; the first sample
            // always lands so a run of all-E_MAX still reports index 0 correctly.
            if ((sample_cnt_reg == '0) || (energy_s < min_energy_reg)) begin
                min_energy_next = energy_s;
                min_index_next  = sample_cnt_reg;
            end
            if (energy_s <= threshold_reg) begin
                thr_hit_next = 1'b1;
                if (hit_cnt_reg != CNT_ONES) begin
                    hit_cnt_next = hit_cnt_reg + CNT_ONE;
                end
            end
            sample_cnt_next = cnt_inc;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= S_IDLE;
        end else if (en_i || clear_i) begin
            state_reg <= state_next;
        end
    end

    // Statistics and configuration registers; frozen while disabled unless cleared.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            num_samples_reg <= '0;
            threshold_reg   <= '0;
            min_energy_reg  <= E_MAX;
            min_index_reg   <= '0;
            hit_cnt_reg     <= '0;
            thr_hit_reg     <= 1'b0;
            sample_cnt_reg  <= '0;
        end else if (en_i || clear_i) begin
            num_samples_reg <= num_samples_next;
            threshold_reg   <= threshold_next;
            min_energy_reg  <= min_energy_next;
            min_index_reg   <= min_index_next;
            hit_cnt_reg     <= hit_cnt_next;
            thr_hit_reg     <= thr_hit_next;
            sample_cnt_reg  <= sample_cnt_next;
        end
    end

    // Result fields come straight from the stats registers, so they are stable
    // throughout REPORT and stay visible in IDLE until the next config.
    assign min_energy_o = min_energy_reg;
    assign min_index_o  = min_index_reg;
    assign hit_cnt_o    = hit_cnt_reg;
    assign thr_hit_o    = thr_hit_reg;

endmodule

// File: tb/tb_energy_tracker.sv
// Scoreboard bench for energy_tracker: each run's expected result is pushed
// when its stimulus is issued and popped when the DUT hands the result over.
module tb_energy_tracker;

    localparam logic signed [31:0] E_MAX = 32'sh7FFF_FFFF;

    typedef struct packed {
        logic signed [31:0] mn;
        logic [15:0]        idx;
        logic [15:0]        hits;
        logic               th;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        clear;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_num_samples;
    logic [31:0] cfg_threshold;
    logic        energy_valid;
    logic        energy_ready;
    logic [31:0] energy;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] min_energy;
    logic [15:0] min_index;
    logic [15:0] hit_cnt;
    logic        thr_hit;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [31:0] e_q[$];
    exp_t               exp_q[$];

    energy_tracker #(.ENERGY_W(32), .CNT_W(16)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .en_i              (en),
        .clear_i           (clear),
        .cfg_valid_i       (cfg_valid),
        .cfg_ready_o       (cfg_ready),
        .cfg_num_samples_i (cfg_num_samples),
        .cfg_threshold_i   (cfg_threshold),
        .energy_valid_i    (energy_valid),
        .energy_ready_o    (energy_ready),
        .energy_i          (energy),
        .result_valid_o    (result_valid),
        .result_ready_i    (result_ready),
        .min_energy_o      (min_energy),
        .min_index_o       (min_index),
        .hit_cnt_o         (hit_cnt),
        .thr_hit_o         (thr_hit),
        .busy_o            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %0s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one run over the first n entries of e_q.
    function automatic exp_t model(input int n, input logic signed [31:0] thr);
        exp_t r;
        r.mn   = E_MAX;
        r.idx  = '0;
        r.hits = '0;
        r.th   = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == 0 || e_q[i] < r.mn) begin
                r.mn  = e_q[i];
                r.idx = 16'(i);
            end
            if (e_q[i] <= thr) begin
                r.hits = r.hits + 16'd1;
                r.th   = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic do_cfg(input int n, input logic signed [31:0] thr);
        int t;
        cfg_num_samples = 16'(n);
        cfg_threshold   = thr;
        cfg_valid       = 1'b1;
        @(negedge clk);
        t = 0;
        while (!cfg_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!cfg_ready) begin
            check_val("cfg_timeout", 64'(cfg_ready), 64'd1);
            cfg_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    // Sends e_q[first..last] back-to-back; ready must be up every cycle.
    task automatic send_burst(input int first, input int last);
        energy_valid = 1'b1;
        for (int i = first; i <= last; i++) begin
            energy = e_q[i];
            @(negedge clk);
            check_val("e_ready", 64'(energy_ready), 64'd1);
            @(posedge clk);
            #1;
        end
        energy_valid = 1'b0;
    endtask

    // Waits for the result, holds ready low for hold cycles checking stability,
    // then accepts it and confirms the return to IDLE.
    task automatic collect_result(input string name, input int hold);
        int   t;
        exp_t e;
        result_ready = 1'b0;
        @(negedge clk);
        t = 0;
        while (!result_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!result_valid) begin
            check_val("res_timeout", 64'(result_valid), 64'd1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        e = exp_q.pop_front();
        for (int h = 0; h < hold; h++) begin
            check_val("hold_valid", 64'(result_valid), 64'd1);
            check_val("hold_min", 64'($signed(min_energy)), 64'(e.mn));
            check_val("hold_idx", 64'(min_index), 64'(e.idx));
            @(negedge clk);
        end
        result_ready = 1'b1;
        check_val("res_valid", 64'(result_valid), 64'd1);
        check_val("res_min", 64'($signed(min_energy)), 64'(e.mn));
        check_val("res_idx", 64'(min_index), 64'(e.idx));
        check_val("res_hits", 64'(hit_cnt), 64'(e.hits));
        check_val("res_thr", 64'(thr_hit), 64'(e.th));
        $display("result %0s: min=%0d idx=%0d hits=%0d thr_hit=%0b", name,
                 $signed(min_energy), min_index, hit_cnt, thr_hit);
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        check_val("idle_valid", 64'(result_valid), 64'd0);
        check_val("idle_cfg_ready", 64'(cfg_ready), 64'd1);
        check_val("idle_busy", 64'(busy), 64'd0);
        check_val("idle_min_kept", 64'($signed(min_energy)), 64'(e.mn));
    endtask

    task automatic run_case(input string name, input int n, input logic signed [31:0] thr,
                            input int hold);
        exp_q.push_back(model(n, thr));
        do_cfg(n, thr);
        if (n > 0) send_burst(0, n - 1);
        check_val("latency", 64'(result_valid), 64'd1);
        collect_result(name, hold);
    endtask

    initial begin
        rst_n           = 1'b0;
        en              = 1'b0;
        clear           = 1'b0;
        cfg_valid       = 1'b0;
        cfg_num_samples = '0;
        cfg_threshold   = '0;
        energy_valid    = 1'b0;
        energy          = '0;
        result_ready    = 1'b0;

        // Reset values, with cfg_ready following en.
        #12;
        check_val("rst_cfg_ready_en0", 64'(cfg_ready), 64'd0);
        en = 1'b1;
        #1;
        check_val("rst_cfg_ready_en1", 64'(cfg_ready), 64'd1);
        check_val("rst_min", 64'($signed(min_energy)), 64'(E_MAX));
        check_val("rst_idx", 64'(min_index), 64'd0);
        check_val("rst_hits", 64'(hit_cnt), 64'd0);
        check_val("rst_thr", 64'(thr_hit), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_rvalid", 64'(result_valid), 64'd0);
        check_val("rst_eready", 64'(energy_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic run with a tie on the minimum.
        e_q = '{32'sd5, -32'sd20, -32'sd20, 32'sd3};
        run_case("basic", 4, -32'sd10, 0);

        // Empty run goes straight to REPORT.
        run_case("empty", 0, 32'sd0, 0);

        // Result held back by the consumer.
        e_q = '{32'sd7, 32'sd7, 32'sd8};
        run_case("backpressure", 3, -32'sd100, 5);

        // Freeze mid-run with a sample offered.
        e_q = '{32'sd3, -32'sd5, -32'sd5, 32'sd10};
        exp_q.push_back(model(4, 32'sd0));
        do_cfg(4, 32'sd0);
        send_burst(0, 1);
        en           = 1'b0;
        energy_valid = 1'b1;
        energy       = -32'sd999;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("frz_eready", 64'(energy_ready), 64'd0);
            check_val("frz_busy", 64'(busy), 64'd1);
        end
        @(posedge clk);
        #1;
        energy_valid = 1'b0;
        en           = 1'b1;
        send_burst(2, 3);
        check_val("frz_latency", 64'(result_valid), 64'd1);
        collect_result("freeze", 0);

        // Clear colliding with an energy accept.
        e_q = '{-32'sd50, -32'sd60, 32'sd0};
        do_cfg(3, 32'sd0);
        send_burst(0, 0);
        energy       = -32'sd60;
        energy_valid = 1'b1;
        clear        = 1'b1;
        @(negedge clk);
        check_val("clr_eready", 64'(energy_ready), 64'd1);
        @(posedge clk);
        #1;
        clear        = 1'b0;
        energy_valid = 1'b0;
        check_val("clr_cfg_ready", 64'(cfg_ready), 64'd1);
        check_val("clr_busy", 64'(busy), 64'd0);
        check_val("clr_min", 64'($signed(min_energy)), 64'(E_MAX));
        check_val("clr_hits", 64'(hit_cnt), 64'd0);
        check_val("clr_thr", 64'(thr_hit), 64'd0);
        $display("clear: min=%0d hits=%0d", $signed(min_energy), hit_cnt);

        // Reset asserted while in REPORT.
        e_q = '{-32'sd1, -32'sd2};
        do_cfg(2, 32'sd0);
        send_burst(0, 1);
        check_val("r38_valid_pre", 64'(result_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("r38_valid", 64'(result_valid), 64'd0);
        check_val("r38_busy", 64'(busy), 64'd0);
        check_val("r38_min", 64'($signed(min_energy)), 64'(E_MAX));
        check_val("r38_idx", 64'(min_index), 64'd0);
        check_val("r38_hits", 64'(hit_cnt), 64'd0);
        check_val("r38_thr", 64'(thr_hit), 64'd0);
        check_val("r38_cfg_ready", 64'(cfg_ready), 64'd1);
        $display("reset in report: valid=%0b min=%0d", result_valid, $signed(min_energy));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        e_q = '{32'sd42};
        run_case("after_reset", 1, 32'sd42, 0);

        // Pseudo-random runs.
        for (int r = 0; r < 3; r++) begin
            logic signed [31:0] thr;
            e_q.delete();
            for (int i = 0; i < 8; i++) begin
                e_q.push_back(32'($signed($urandom_range(0, 200)) - 100));
            end
            thr = 32'($signed($urandom_range(0, 100)) - 50);
            run_case("random", 8, thr, r);
        end

        check_val("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
